// File: rtl/pe_operand_feeder.sv
// Operand/result sequencer for one multiply-accumulate PE: clears the PE, streams operand pairs,
// waits out the PE pipeline and returns the accumulation. Optional build macro: PE_FEEDER_SHADOW_EN.
module pe_operand_feeder #(
   parameter int BW     = 8,
   parameter int K_MAX  = 16,
   parameter int PE_LAT = 1,
   parameter int CW     = $clog2(K_MAX+1)
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [BW-1:0]   i_in_act,
   input  logic [BW-1:0]   i_in_weight,
   input  logic            i_in_last,
   output logic [BW-1:0]   o_pe_activation,
   output logic [BW-1:0]   o_pe_weight,
   output logic            o_pe_clear,
   input  logic [2*BW-1:0] i_pe_output,
   output logic            o_res_valid,
   input  logic            i_res_ready,
   output logic [2*BW-1:0] o_res_data,
   output logic [CW-1:0]   o_res_count
`ifdef PE_FEEDER_SHADOW_EN
   ,
   output logic            o_res_mismatch
`endif
);

   // state  | meaning
   // CLEAR  | one cycle, PE accumulator cleared, beat count reset
   // STREAM | accepting operand beats, one pair per cycle onto the PE
   // DRAIN  | PE_LAT+1 cycles of zero operands while the PE pipeline settles
   // HOLD   | result presented until the consumer takes it

   localparam int DW = $clog2(PE_LAT+2);

   typedef enum logic [1:0] {
      S_CLEAR  = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   beat_cnt;
   logic [DW-1:0]   drain_cnt;
   logic            hs;
   logic            beat_term;
   logic            drain_done;

   assign hs         = i_in_valid & o_in_ready;
   // Reaching K_MAX beats implies the last flag; further beats belong to the next product.
   assign beat_term  = i_in_last | (beat_cnt == CW'(K_MAX-1));
   assign drain_done = (drain_cnt == '0);

   always_ff @(posedge i_clock) begin
      if (i_reset) state <= S_CLEAR;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR:  state_nxt = S_STREAM;
         S_STREAM: if (hs && beat_term) state_nxt = S_DRAIN;
         S_DRAIN:  if (drain_done) state_nxt = S_HOLD;
         S_HOLD:   if (i_res_ready) state_nxt = S_CLEAR;
         default:  state_nxt = S_CLEAR;
      endcase
   end

   always_comb begin
      o_in_ready  = (state == S_STREAM);
      o_pe_clear  = (state == S_CLEAR);
      o_res_valid = (state == S_HOLD);
   end

   // Idle stream cycles present 0/0 so the PE adds nothing.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_pe_activation <= '0;
         o_pe_weight     <= '0;
         beat_cnt        <= '0;
         drain_cnt       <= '0;
         o_res_data      <= '0;
         o_res_count     <= '0;
      end else begin
         o_pe_activation <= hs ? i_in_act    : '0;
         o_pe_weight     <= hs ? i_in_weight : '0;
         case (state)
            S_CLEAR: beat_cnt <= '0;
            S_STREAM: begin
               if (hs) begin
                  beat_cnt <= beat_cnt + CW'(1);
                  if (beat_term) drain_cnt <= DW'(PE_LAT);
               end
            end
            S_DRAIN: begin
               if (drain_done) begin
                  o_res_data  <= i_pe_output;
                  o_res_count <= beat_cnt;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PE_FEEDER_SHADOW_EN
   logic [2*BW-1:0] shadow;
   logic [2*BW-1:0] prod;

   assign prod = (2*BW)'(i_in_act) * (2*BW)'(i_in_weight);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         shadow         <= '0;
         o_res_mismatch <= 1'b0;
      end else begin
         case (state)
            S_CLEAR:  shadow <= '0;
            S_STREAM: if (hs) shadow <= shadow + prod;
            S_DRAIN:  if (drain_done) o_res_mismatch <= (i_pe_output != shadow);
            default: ;
         endcase
      end
   end
`endif

endmodule
